mini_alu_core: RTL and testbench

Parametrised successor to the team's single-issue MiniAlu pipeline. It adds configurable data, register-address and instruction-address widths, a hardware return-address stack for nested CALL/RET, and logic ops. It sits between the instruction ROM (external, combinational read) and the LED and video-memory write ports of the VGA subsystem. The pipeline has two stages: fetch/decode, then execute/writeback. The register file is internal, with forwarding for back-to-back dependencies.

---
 rtl/mini_alu_core.sv | 144 ++++++++++++++
 tb/tb_mini_alu_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_alu_core.sv
// Two-stage MiniAlu core: fetch/decode then execute/writeback, with forwarding and a return-address stack.
// Define MINI_ALU_MUL_EN to make opcode F a single-cycle MUL; otherwise F executes as NOP.
module mini_alu_core #(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 8,
  parameter int IADDR_W     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [IADDR_W-1:0]     oIP,
  input  logic [4+3*RADDR_W-1:0] iInstruction,
  output logic [7:0]             oLed,
  output logic                   oVideoWrite,
  output logic [DATA_W-1:0]      oVideoAddr,
  output logic [2:0]             oVideoData,
  output logic                   oStackError
);

  localparam int IW     = 4 + 3*RADDR_W;
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LED = 4'h1, OP_STO = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_BLE = 4'h5, OP_JMP = 4'h6, OP_CALL = 4'h7,
    OP_RET = 4'h8, OP_WVM = 4'h9, OP_AND = 4'hA, OP_OR  = 4'hB,
    OP_XOR = 4'hC, OP_SHL = 4'hD, OP_SHR = 4'hE, OP_MUL = 4'hF
  } op_e;

  logic [IADDR_W-1:0] r_ip;
  logic [IW-1:0]      r_ex_instr;
  logic [DATA_W-1:0]  r_rd0, r_rd1;
  logic [DATA_W-1:0]  r_rf [2**RADDR_W];
  logic               r_fwd_vld;
  logic [RADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0]  r_fwd_data;
  logic [IADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]    r_sp;
  logic [7:0]         r_led;
  logic               r_err;

  op_e                w_op;
  logic [RADDR_W-1:0] w_dst, w_src1, w_src0, w_f_src1, w_f_src0;
  logic [DATA_W-1:0]  w_a, w_b, w_res;
  logic [IADDR_W-1:0] w_tgt;
  logic [SIDX_W-1:0]  w_top_idx, w_wr_idx;
  logic               w_we, w_br, w_push, w_pop, w_err_set, w_led_we, w_vw;

  assign w_op     = op_e'(r_ex_instr[IW-1 -: 4]);
  assign w_dst    = r_ex_instr[3*RADDR_W-1 -: RADDR_W];
  assign w_src1   = r_ex_instr[2*RADDR_W-1 -: RADDR_W];
  assign w_src0   = r_ex_instr[RADDR_W-1:0];
  assign w_f_src1 = iInstruction[2*RADDR_W-1 -: RADDR_W];
  assign w_f_src0 = iInstruction[RADDR_W-1:0];

  // The RAM read was issued before the previous result landed, so patch it here.
  assign w_a = (r_fwd_vld && r_fwd_addr == w_src1) ? r_fwd_data : r_rd1;
  assign w_b = (r_fwd_vld && r_fwd_addr == w_src0) ? r_fwd_data : r_rd0;

  assign w_top_idx = SIDX_W'(r_sp - SP_W'(1));
  assign w_wr_idx  = SIDX_W'(r_sp);

  always_comb begin
    w_we      = 1'b0;
    w_res     = '0;
    w_br      = 1'b0;
    w_tgt     = IADDR_W'(w_dst);
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    w_led_we  = 1'b0;
    w_vw      = 1'b0;
    case (w_op)
      OP_LED: w_led_we = 1'b1;
      OP_STO: begin w_we = 1'b1; w_res = DATA_W'({w_src1, w_src0}); end
      OP_ADD: begin w_we = 1'b1; w_res = w_a + w_b; end
      OP_SUB: begin w_we = 1'b1; w_res = w_a - w_b; end
      OP_AND: begin w_we = 1'b1; w_res = w_a & w_b; end
      OP_OR:  begin w_we = 1'b1; w_res = w_a | w_b; end
      OP_XOR: begin w_we = 1'b1; w_res = w_a ^ w_b; end
      OP_SHL: begin w_we = 1'b1; w_res = w_a << w_b[3:0]; end
      OP_SHR: begin w_we = 1'b1; w_res = w_a >> w_b[3:0]; end
      OP_BLE: w_br = (w_a <= w_b);
      OP_JMP: w_br = 1'b1;
      OP_CALL: begin
        w_br = 1'b1;
        if (r_sp == SP_FULL) w_err_set = 1'b1;
        else                 w_push    = 1'b1;
      end
      OP_RET: begin
        if (r_sp == '0) w_err_set = 1'b1;
        else begin
          w_pop = 1'b1;
          w_br  = 1'b1;
          w_tgt = r_stack[w_top_idx];
        end
      end
      OP_WVM: w_vw = 1'b1;
`ifdef MINI_ALU_MUL_EN
      OP_MUL: begin w_we = 1'b1; w_res = w_a * w_b; end
`endif
      default: ;
    endcase
  end

  assign oIP         = Reset ? '0 : (w_br ? w_tgt : r_ip);
  assign oVideoWrite = w_vw && !Reset;
  assign oVideoAddr  = w_b;
  assign oVideoData  = w_a[2:0];
  assign oLed        = r_led;
  assign oStackError = r_err;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ip       <= '0;
      r_ex_instr <= '0;
      r_led      <= '0;
      r_sp       <= '0;
      r_err      <= 1'b0;
      r_fwd_vld  <= 1'b0;
    end else begin
      r_ip       <= oIP + IADDR_W'(1);
      r_ex_instr <= iInstruction;
      r_fwd_vld  <= w_we;
      r_fwd_addr <= w_dst;
      r_fwd_data <= w_res;
      if (w_led_we)  r_led <= w_a[7:0];
      if (w_err_set) r_err <= 1'b1;
      if (w_push)     r_sp <= r_sp + SP_W'(1);
      else if (w_pop) r_sp <= r_sp - SP_W'(1);
    end
  end

  // Storage arrays are never cleared; only the in-flight op is squashed by Reset.
  always_ff @(posedge Clock) begin
    r_rd0 <= r_rf[w_f_src0];
    r_rd1 <= r_rf[w_f_src1];
    if (!Reset && w_we)   r_rf[w_dst]       <= w_res;
    if (!Reset && w_push) r_stack[w_wr_idx] <= r_ip;
  end

endmodule

// File: tb/tb_mini_alu_core.sv
// Randomized and directed programs run against an instruction-level reference model; a per-cycle monitor scores the DUT.
module tb_mini_alu_core;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ip;
  logic [27:0] instr;
  logic [7:0]  led;
  logic        vw;
  logic [15:0] vaddr;
  logic [2:0]  vdata;
  logic        serr;

  always #5 clk = ~clk;

  mini_alu_core dut (
    .Clock(clk), .Reset(rst), .oIP(ip), .iInstruction(instr), .oLed(led),
    .oVideoWrite(vw), .oVideoAddr(vaddr), .oVideoData(vdata), .oStackError(serr)
  );

  logic [27:0] rom_mem [256];
  always_comb instr = (ip < 16'd256) ? rom_mem[ip[7:0]] : 28'h0;

  typedef struct {
    logic [15:0] ip;
    logic        vw;
    logic [15:0] va;
    logic [2:0]  vd;
    logic [7:0]  led;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Instruction-level model: executes whole instructions, no pipeline notion.
  logic [15:0] mR [256];
  logic [15:0] mpc;
  logic [15:0] mstk[$];
  logic [7:0]  mled;
  logic        merr;

  function automatic logic [27:0] rom_at(input logic [15:0] a);
    return (a < 16'd256) ? rom_mem[a[7:0]] : 28'h0;
  endfunction

  task automatic m_step(input bit commit);
    logic [3:0]  op;
    logic [7:0]  d, s1, s0, nled;
    logic [15:0] a, b, res, nxt;
    logic [31:0] prod;
    bit          wr, push, pop, nerr;
    exp_t        e;
    {op, d, s1, s0} = rom_at(mpc);
    a = mR[s1]; b = mR[s0];
    nxt = mpc + 16'd1; res = '0; prod = '0;
    wr = 0; push = 0; pop = 0; nled = mled; nerr = merr;
    e.vw = 1'b0; e.va = '0; e.vd = '0;
    case (op)
      4'h1: nled = a[7:0];
      4'h2: begin wr = 1; res = {s1, s0}; end
      4'h3: begin wr = 1; res = a + b; end
      4'h4: begin wr = 1; res = a - b; end
      4'h5: if (a <= b) nxt = {8'h00, d};
      4'h6: nxt = {8'h00, d};
      4'h7: begin nxt = {8'h00, d}; if (mstk.size() < SD) push = 1; else nerr = 1; end
      4'h8: if (mstk.size() > 0) begin nxt = mstk[$]; pop = 1; end else nerr = 1;
      4'h9: begin e.vw = 1'b1; e.va = b; e.vd = a[2:0]; end
      4'hA: begin wr = 1; res = a & b; end
      4'hB: begin wr = 1; res = a | b; end
      4'hC: begin wr = 1; res = a ^ b; end
      4'hD: begin wr = 1; res = a << b[3:0]; end
      4'hE: begin wr = 1; res = a >> b[3:0]; end
`ifdef MINI_ALU_MUL_EN
      4'hF: begin wr = 1; prod = {16'h0, a} * {16'h0, b}; res = prod[15:0]; end
`endif
      default: ;
    endcase
    e.ip = nxt; e.led = mled; e.err = merr;
    q.push_back(e);
    if (commit) begin
      if (wr) mR[d] = res;
      if (push) mstk.push_back(mpc + 16'd1);
      if (pop) void'(mstk.pop_back());
      mled = nled; merr = nerr; mpc = nxt;
    end
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (mon_on) begin
      if (q.size() == 0) chk("queue_underrun", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("oIP", {16'h0, ip}, {16'h0, e.ip});
        chk("oVideoWrite", {31'h0, vw}, {31'h0, e.vw});
        if (e.vw) begin
          chk("oVideoAddr", {16'h0, vaddr}, {16'h0, e.va});
          chk("oVideoData", {29'h0, vdata}, {29'h0, e.vd});
        end
        chk("oLed", {24'h0, led}, {24'h0, e.led});
        chk("oStackError", {31'h0, serr}, {31'h0, e.err});
      end
    end
  end

  // Runs the loaded ROM for n execute cycles from reset, then reasserts Reset while
  // instruction n is still executing, so that instruction must leave no trace.
  task automatic run(input int n, input bit fin, input logic [7:0] fled, input logic ferr);
    exp_t e0;
    mpc = '0; mstk.delete(); mled = '0; merr = 1'b0;
    e0.ip = '0; e0.vw = 1'b0; e0.va = '0; e0.vd = '0; e0.led = '0; e0.err = 1'b0;
    q.push_back(e0);
    for (int i = 0; i < n; i++) m_step(i < n - 1);
    @(negedge clk);
    rst = 1'b0; mon_on = 1'b1;
    repeat (n) @(negedge clk);
    #3;
    if (fin) begin
      chk("final_led", {24'h0, led}, {24'h0, fled});
      chk("final_err", {31'h0, serr}, {31'h0, ferr});
    end
    mon_on = 1'b0;
    chk("queue_drained", q.size(), 32'd0);
    q.delete();
    rst = 1'b1;
    #1;
    chk("rst_oIP", {16'h0, ip}, 32'd0);
    chk("rst_oVideoWrite", {31'h0, vw}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oLed", {24'h0, led}, 32'd0);
    chk("rst_oStackError", {31'h0, serr}, 32'd0);
  endtask

  function automatic logic [27:0] I(input logic [3:0] op, input logic [7:0] d, input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] STO(input logic [7:0] d, input logic [15:0] v);
    return {4'h2, d, v};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = 28'h0;
  endtask

  initial begin
    clear_rom();
    repeat (2) @(posedge clk);
    #1;
    chk("init_oIP", {16'h0, ip}, 32'd0);
    chk("init_oLed", {24'h0, led}, 32'd0);
    chk("init_oStackError", {31'h0, serr}, 32'd0);
    chk("init_oVideoWrite", {31'h0, vw}, 32'd0);

    // Give R0..R7 defined contents.
    for (int i = 0; i < 8; i++) rom_mem[i] = STO(8'(i), 16'($urandom));
    run(9, 0, 8'h00, 1'b0);

    // Straight-line code.
    clear_rom();
    rom_mem[0] = STO(8'd1, 16'd5);
    rom_mem[1] = STO(8'd2, 16'd7);
    rom_mem[2] = I(4'h3, 8'd3, 8'd2, 8'd1);
    rom_mem[3] = I(4'h1, 8'd0, 8'd3, 8'd0);
    run(6, 1, 8'h0C, 1'b0);

    // Back-to-back dependencies.
    clear_rom();
    rom_mem[0] = STO(8'd1, 16'd3);
    rom_mem[1] = I(4'h3, 8'd1, 8'd1, 8'd1);
    rom_mem[2] = I(4'h3, 8'd1, 8'd1, 8'd1);
    rom_mem[3] = I(4'h1, 8'd0, 8'd1, 8'd0);
    run(6, 1, 8'h0C, 1'b0);

    // BLE taken on equality, then falls through when src1 is larger.
    clear_rom();
    rom_mem[0]  = STO(8'd1, 16'd4);
    rom_mem[1]  = STO(8'd2, 16'd4);
    rom_mem[2]  = I(4'h5, 8'h20, 8'd1, 8'd2);
    rom_mem[3]  = STO(8'd6, 16'h0055);
    rom_mem[4]  = I(4'h1, 8'd0, 8'd6, 8'd0);
    rom_mem[32] = I(4'h1, 8'd0, 8'd1, 8'd0);
    run(7, 1, 8'h04, 1'b0);
    rom_mem[0]  = STO(8'd1, 16'd5);
    run(7, 1, 8'h55, 1'b0);

    // Nested CALL/RET.
    clear_rom();
    rom_mem[2]  = I(4'h7, 8'd10, 8'd0, 8'd0);
    rom_mem[3]  = STO(8'd7, 16'h0099);
    rom_mem[4]  = I(4'h1, 8'd0, 8'd7, 8'd0);
    rom_mem[11] = I(4'h7, 8'd20, 8'd0, 8'd0);
    rom_mem[12] = I(4'h8, 8'd0, 8'd0, 8'd0);
    rom_mem[20] = I(4'h8, 8'd0, 8'd0, 8'd0);
    run(10, 1, 8'h99, 1'b0);

    // One CALL more than the stack holds.
    clear_rom();
    rom_mem[0]  = I(4'h7, 8'd10, 8'd0, 8'd0);
    rom_mem[10] = I(4'h7, 8'd20, 8'd0, 8'd0);
    rom_mem[20] = I(4'h7, 8'd30, 8'd0, 8'd0);
    rom_mem[30] = I(4'h7, 8'd40, 8'd0, 8'd0);
    rom_mem[40] = I(4'h7, 8'd50, 8'd0, 8'd0);
    rom_mem[50] = STO(8'd7, 16'h00A5);
    rom_mem[51] = I(4'h1, 8'd0, 8'd7, 8'd0);
    run(9, 1, 8'hA5, 1'b1);

    // RET with an empty stack.
    clear_rom();
    rom_mem[5] = I(4'h8, 8'd0, 8'd0, 8'd0);
    rom_mem[6] = STO(8'd7, 16'h003C);
    rom_mem[7] = I(4'h1, 8'd0, 8'd7, 8'd0);
    run(10, 1, 8'h3C, 1'b1);

    // Video write using a freshly forwarded operand.
    clear_rom();
    rom_mem[0] = STO(8'd4, 16'h03FF);
    rom_mem[1] = STO(8'd5, 16'd6);
    rom_mem[2] = I(4'h9, 8'd0, 8'd5, 8'd4);
    rom_mem[3] = I(4'h1, 8'd0, 8'd5, 8'd0);
    run(6, 1, 8'h06, 1'b0);

    // Opcode F: product low bits, or no effect on R3 (still 0x0C) when disabled.
    clear_rom();
    rom_mem[0] = STO(8'd1, 16'd300);
    rom_mem[1] = STO(8'd2, 16'd300);
    rom_mem[2] = I(4'hF, 8'd3, 8'd1, 8'd2);
    rom_mem[3] = I(4'h1, 8'd0, 8'd3, 8'd0);
    rom_mem[4] = I(4'h9, 8'd0, 8'd3, 8'd3);
`ifdef MINI_ALU_MUL_EN
    run(7, 1, 8'h90, 1'b0);
`else
    run(7, 1, 8'h0C, 1'b0);
`endif

    // A write squashed by Reset must not reach the register file.
    clear_rom();
    rom_mem[0] = STO(8'd6, 16'd1);
    rom_mem[1] = STO(8'd6, 16'd2);
    run(2, 0, 8'h00, 1'b0);
    rom_mem[0] = I(4'h1, 8'd0, 8'd6, 8'd0);
    rom_mem[1] = 28'h0;
    run(3, 1, 8'h01, 1'b0);

    // Random programs over R0..R7 with branches inside the first 64 words.
    for (int p = 0; p < 6; p++) begin
      logic [3:0] op;
      clear_rom();
      for (int i = 0; i < 8; i++) rom_mem[i] = STO(8'(i), 16'($urandom));
      for (int a = 8; a < 64; a++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h2)
          rom_mem[a] = STO(8'($urandom_range(0, 7)), 16'($urandom));
        else if (op == 4'h5 || op == 4'h6 || op == 4'h7)
          rom_mem[a] = I(op, 8'($urandom_range(0, 63)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
        else
          rom_mem[a] = I(op, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
      end
      run(150, 0, 8'h00, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
